fixed_sqrt_hs: RTL and testbench

FIXED_SQRT_HS -- requirements
Module: fixed_sqrt_hs

---
 rtl/fixed_sqrt_hs.sv | 113 +++++++++++
 tb/tb_fixed_sqrt_hs.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fixed_sqrt_hs.sv
// Handshaked unsigned fixed-point square root, one root bit per clock (restoring digit recurrence).
// Result is Q(WIDTH-FRAC).FRAC; remainder and exact flag always refer to the truncated root.
module fixed_sqrt_hs #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sqrt_out,
    output logic [WIDTH:0]   rem_out,
    output logic             exact
);
    localparam int W2   = WIDTH + FRAC + ((WIDTH + FRAC) % 2);
    localparam int ITER = W2 / 2;
    localparam int RW   = ITER + 2;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [W2-1:0]     r_n;
    logic [ITER-1:0]   r_root;
    logic [RW-1:0]     r_rem;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_sqrt;
    logic [WIDTH:0]    r_rem_o;
    logic              r_exact;

    logic              w_acc;
    logic              w_last;
    logic [RW-1:0]     w_rem_sh;
    logic [RW-1:0]     w_trial;
    logic              w_ge;
    logic [RW-1:0]     w_rem_nx;
    logic [ITER-1:0]   w_root_nx;
    logic              w_rnd_up;
    logic [WIDTH:0]    w_sq_inc;
    logic [WIDTH-1:0]  w_sq_fin;

    assign w_acc  = (r_state == S_IDLE) && in_valid;
    assign w_last = (r_state == S_CALC) && (r_cnt == '0);

    // Bring down the next two operand bits and try subtracting 4R+1.
    assign w_rem_sh  = {r_rem[RW-3:0], r_n[W2-1 -: 2]};
    assign w_trial   = {r_root, 2'b01};
    assign w_ge      = (w_rem_sh >= w_trial);
    assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nx = {r_root[ITER-2:0], w_ge};

    // Root+1 is nearer whenever remainder exceeds R; clamp at all-ones.
    assign w_rnd_up = (ROUND != 0) && (w_rem_nx > RW'(w_root_nx));
    assign w_sq_inc = (WIDTH+1)'(w_root_nx) + (WIDTH+1)'(1);
    assign w_sq_fin = !w_rnd_up       ? WIDTH'(w_root_nx) :
                      w_sq_inc[WIDTH] ? '1                : w_sq_inc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nx = S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nx = S_DONE;
            S_DONE:  if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_sqrt  <= '0;
            r_rem_o <= '0;
            r_exact <= 1'b0;
        end else if (w_acc) begin
            r_n    <= W2'(x_in) << FRAC;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= CW'(ITER - 1);
        end else if (r_state == S_CALC) begin
            r_n    <= r_n << 2;
            r_root <= w_root_nx;
            r_rem  <= w_rem_nx;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_sqrt  <= w_sq_fin;
                r_rem_o <= (WIDTH+1)'(w_rem_nx);
                r_exact <= (w_rem_nx == '0);
            end
        end
    end

    assign sqrt_out = r_sqrt;
    assign rem_out  = r_rem_o;
    assign exact    = r_exact;
endmodule

// File: tb/tb_fixed_sqrt_hs.sv
// Directed bench for fixed_sqrt_hs: truncating and rounding instances driven side by side,
// expectations from hand values and an independent bit-search integer square root.
module tb_fixed_sqrt_hs;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] x_in;
    logic        out_ready;
    logic        in_ready0, out_valid0, exact0;
    logic        in_ready1, out_valid1, exact1;
    logic [15:0] sqrt0, sqrt1;
    logic [16:0] rem0, rem1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fixed_sqrt_hs #(.WIDTH(16), .FRAC(8), .ROUND(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x_in(x_in),
        .out_valid(out_valid0), .out_ready(out_ready), .sqrt_out(sqrt0), .rem_out(rem0),
        .exact(exact0));

    fixed_sqrt_hs #(.WIDTH(16), .FRAC(8), .ROUND(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .x_in(x_in),
        .out_valid(out_valid1), .out_ready(out_ready), .sqrt_out(sqrt1), .rem_out(rem1),
        .exact(exact1));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Largest r with r*r <= x*256, found by testing bits from the top.
    task automatic model(input logic [15:0] x, output int r, output int rem);
        int n;
        n = int'(x) * 256;
        r = 0;
        for (int b = 11; b >= 0; b--)
            if ((r | (1 << b)) * (r | (1 << b)) <= n) r = r | (1 << b);
        rem = n - r * r;
    endtask

    // Called at a negedge; returns at a negedge after the result handshake.
    task automatic run_op(input logic [15:0] x, input int stall, input bit churn, input string tag);
        int r, rem, rr, cyc;
        bit seen;
        model(x, r, rem);
        rr = (rem > r) ? ((r + 1 > 65535) ? 65535 : r + 1) : r;
        in_valid = 1'b1;
        x_in     = x;
        chk({tag, ".in_ready"}, 32'(in_ready0), 1);
        @(posedge clk);
        @(negedge clk);
        if (!churn) in_valid = 1'b0;
        chk({tag, ".busy"}, 32'(in_ready0), 0);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            if (out_valid0) seen = 1'b1;
            else begin
                if (churn) x_in = 16'($urandom);
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        chk({tag, ".out_valid"}, 32'(seen), 1);
        chk({tag, ".latency"}, 32'(cyc), 12);
        chk({tag, ".sqrt_r0"}, 32'(sqrt0), 32'(r));
        chk({tag, ".sqrt_r1"}, 32'(sqrt1), 32'(rr));
        chk({tag, ".rem_r0"}, 32'(rem0), 32'(rem));
        chk({tag, ".rem_r1"}, 32'(rem1), 32'(rem));
        chk({tag, ".exact"}, 32'(exact0), 32'(rem == 0));
        chk({tag, ".out_valid_r1"}, 32'(out_valid1), 1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_sqrt"}, 32'(sqrt0), 32'(r));
            chk({tag, ".hold_rem"}, 32'(rem0), 32'(rem));
            chk({tag, ".hold_in_ready"}, 32'(in_ready0), 0);
            chk({tag, ".hold_out_valid"}, 32'(out_valid0), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".idle_out_valid"}, 32'(out_valid0), 0);
        chk({tag, ".idle_in_ready"}, 32'(in_ready0), 1);
        chk({tag, ".retain_sqrt"}, 32'(sqrt0), 32'(r));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.in_ready", 32'(in_ready0), 1);
        chk("rst.out_valid", 32'(out_valid0), 0);
        chk("rst.sqrt", 32'(sqrt0), 0);
        chk("rst.rem", 32'(rem0), 0);
        chk("rst.exact", 32'(exact0), 0);

        // Hand values: 4.0 -> 2.0 exact; 2.0 -> 0x16A rem 28; 0xFFFF -> 0xFFF / 0x1000 rem 7935.
        run_op(16'h0400, 0, 1'b0, "x4");
        chk("x4.hand", 32'(sqrt0), 32'h0200);
        run_op(16'h0200, 0, 1'b0, "x2");
        chk("x2.hand_r0", 32'(sqrt0), 32'h016A);
        chk("x2.hand_r1", 32'(sqrt1), 32'h016A);
        chk("x2.hand_rem", 32'(rem0), 28);
        run_op(16'hFFFF, 0, 1'b0, "xmax");
        chk("xmax.hand_r0", 32'(sqrt0), 32'h0FFF);
        chk("xmax.hand_r1", 32'(sqrt1), 32'h1000);
        chk("xmax.hand_rem", 32'(rem1), 7935);
        run_op(16'h0000, 20, 1'b0, "x0");
        chk("x0.hand_exact", 32'(exact0), 1);

        // Reset in the middle of CALC discards the operand.
        in_valid = 1'b1;
        x_in     = 16'h0400;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.in_ready", 32'(in_ready0), 1);
        chk("midrst.out_valid", 32'(out_valid0), 0);
        chk("midrst.sqrt", 32'(sqrt0), 0);
        run_op(16'h0900, 0, 1'b0, "x9");
        chk("x9.hand", 32'(sqrt0), 32'h0300);

        run_op(16'h1234, 0, 1'b1, "churn");
        for (int k = 0; k < 16; k++) run_op(16'($urandom), 0, 1'b0, "sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
